// File: rtl/dec_entry.sv
// Decimal number-entry unit: debounced digit keys accumulate into a binary value,
// which is handed to the consumer through a valid/ack handshake on commit.
module dec_entry #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_DIGITS      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            btn,
  input  logic [3:0]            sw,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [2:0]            digits,
  output logic                  err
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW   = DATA_WIDTH + 4;

  typedef enum logic [1:0] {StEntry, StCalc, StWait} state_e;

  logic [2:0]           btn_s1_q, btn_s2_q;
  logic [3:0]           sw_s1_q, sw_s2_q;
  logic [2:0]           deb_q, deb_d;
  logic [2:0][CntW-1:0] cnt_q, cnt_d;
  logic [2:0]           press_q;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, data_q, data_d;
  logic [2:0]            digits_q, digits_d;
  logic                  err_q, err_d, valid_q, valid_d;
  logic [3:0]            digit_q, digit_d;

  logic          ev_clr, ev_com, ev_ent;
  logic [TW-1:0] t;
  logic          reject;

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (btn_s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i] = btn_s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= 3'b111;
      btn_s2_q <= 3'b111;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      deb_q    <= 3'b111;
      cnt_q    <= '0;
      press_q  <= '0;
    end else begin
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      press_q  <= deb_q & ~deb_d;  // released (1) -> pressed (0) only
    end
  end

  assign ev_clr = press_q[2];
  assign ev_com = press_q[1] & ~press_q[2];
  assign ev_ent = press_q[0] & ~(|press_q[2:1]);

  assign t      = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + TW'(digit_q);
  assign reject = (digit_q > 4'd9) || (digits_q == 3'(MAX_DIGITS)) ||
                  (t[TW-1:DATA_WIDTH] != '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    digits_d = digits_q;
    err_d    = err_q;
    data_d   = data_q;
    valid_d  = valid_q;
    digit_d  = digit_q;
    unique case (state_q)
      StEntry: begin
        if (ev_clr) begin
          acc_d    = '0;
          digits_d = '0;
          err_d    = 1'b0;
        end else if (ev_com) begin
          data_d  = acc_q;
          valid_d = 1'b1;
          state_d = StWait;
        end else if (ev_ent) begin
          digit_d = sw_s2_q;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (reject) begin
          err_d = 1'b1;
        end else begin
          acc_d    = t[DATA_WIDTH-1:0];
          digits_d = digits_q + 3'd1;
        end
        state_d = StEntry;
      end
      StWait: begin
        if (ack) begin
          valid_d  = 1'b0;
          acc_d    = '0;
          digits_d = '0;
          err_d    = 1'b0;
          state_d  = StEntry;
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEntry;
      acc_q    <= '0;
      digits_q <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      digit_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      digits_q <= digits_d;
      err_q    <= err_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      digit_q  <= digit_d;
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign acc    = acc_q;
  assign digits = digits_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dec_entry.sv
// Bench for dec_entry: directed scenarios plus random key sequences checked against
// an arithmetic model of decimal entry.
module tb_dec_entry;

  logic        clk;
  logic        rst_n;
  logic [2:0]  btn;
  logic [3:0]  sw;
  logic        ack;
  logic [15:0] data;
  logic        valid;
  logic [15:0] acc;
  logic [2:0]  digits;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   m_acc;
  int   m_digits;
  logic m_err;

  dec_entry #(
    .DATA_WIDTH     (16),
    .DEBOUNCE_CYCLES(4),
    .MAX_DIGITS     (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .sw    (sw),
    .ack   (ack),
    .data  (data),
    .valid (valid),
    .acc   (acc),
    .digits(digits),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the masked buttons pressed long enough to debounce, then release them.
  task automatic press(input logic [2:0] mask, input logic [3:0] d);
    sw  = d;
    btn = ~mask;
    cyc(12);
    btn = 3'b111;
    cyc(12);
  endtask

  task automatic model_enter(input int d);
    if (d > 9 || m_digits == 5 || m_acc * 10 + d > 65535) m_err = 1'b1;
    else begin
      m_acc    = m_acc * 10 + d;
      m_digits = m_digits + 1;
    end
  endtask

  task automatic model_clear();
    m_acc    = 0;
    m_digits = 0;
    m_err    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 3'b111;
    sw    = 4'd0;
    ack   = 1'b0;
    cyc(3);
    checks++;
    if ({valid, data, acc, digits, err} !== 36'd0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%0d acc=%0d digits=%0d err=%b, want all 0",
               valid, data, acc, digits, err);
    end
    rst_n = 1'b1;
    cyc(2);
    model_clear();
  endtask

  task automatic test_debounce();
    sw = 4'd7;
    btn = 3'b110; cyc(2);
    btn = 3'b111; cyc(2);
    btn = 3'b110; cyc(2);
    btn = 3'b111; cyc(12);
    checks++;
    if (acc !== 16'd0 || digits !== 3'd0) begin
      errors++;
      $display("FAIL debounce_glitch: acc=%0d digits=%0d, want 0 0", acc, digits);
    end
    btn = 3'b110; cyc(10);
    checks++;
    if (acc !== 16'd7 || digits !== 3'd1) begin
      errors++;
      $display("FAIL debounce_hold10: acc=%0d digits=%0d, want 7 1", acc, digits);
    end
    cyc(30);
    btn = 3'b111; cyc(12);
    checks++;
    if (acc !== 16'd7 || digits !== 3'd1) begin
      errors++;
      $display("FAIL debounce_one_event: acc=%0d digits=%0d, want 7 1", acc, digits);
    end
    press(3'b100, 4'd0);
    model_clear();
  endtask

  task automatic test_handshake();
    press(3'b001, 4'd1);
    press(3'b001, 4'd2);
    press(3'b001, 4'd3);
    press(3'b010, 4'd0);
    checks++;
    if (valid !== 1'b1 || data !== 16'd123) begin
      errors++;
      $display("FAIL hs_commit: valid=%b data=%0d, want 1 123", valid, data);
    end
    ack = 1'b0;
    cyc(5);
    press(3'b100, 4'd0);
    checks++;
    if (valid !== 1'b1 || data !== 16'd123 || acc !== 16'd123 || digits !== 3'd3) begin
      errors++;
      $display("FAIL hs_hold: valid=%b data=%0d acc=%0d digits=%0d, want 1 123 123 3",
               valid, data, acc, digits);
    end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || acc !== 16'd0 || digits !== 3'd0) begin
      errors++;
      $display("FAIL hs_ack: valid=%b acc=%0d digits=%0d, want 0 0 0", valid, acc, digits);
    end
    model_clear();
  endtask

  task automatic test_overflow();
    int seq_a[5] = '{6, 5, 5, 3, 5};
    int seq_b[5] = '{6, 5, 5, 3, 6};
    foreach (seq_a[i]) press(3'b001, 4'(seq_a[i]));
    checks++;
    if (acc !== 16'd65535 || err !== 1'b0 || digits !== 3'd5) begin
      errors++;
      $display("FAIL ovf_max: acc=%0d digits=%0d err=%b, want 65535 5 0", acc, digits, err);
    end
    press(3'b100, 4'd0);
    foreach (seq_b[i]) press(3'b001, 4'(seq_b[i]));
    checks++;
    if (acc !== 16'd6553 || digits !== 3'd4 || err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_reject: acc=%0d digits=%0d err=%b, want 6553 4 1", acc, digits, err);
    end
    press(3'b100, 4'd0);
    model_clear();
  endtask

  task automatic test_invalid_limit();
    press(3'b001, 4'd8);
    press(3'b001, 4'd12);
    checks++;
    if (acc !== 16'd8 || digits !== 3'd1 || err !== 1'b1) begin
      errors++;
      $display("FAIL bad_digit: acc=%0d digits=%0d err=%b, want 8 1 1", acc, digits, err);
    end
    press(3'b100, 4'd0);
    repeat (5) press(3'b001, 4'd0);
    checks++;
    if (acc !== 16'd0 || digits !== 3'd5 || err !== 1'b0) begin
      errors++;
      $display("FAIL five_zeros: acc=%0d digits=%0d err=%b, want 0 5 0", acc, digits, err);
    end
    press(3'b001, 4'd0);
    checks++;
    if (digits !== 3'd5 || err !== 1'b1) begin
      errors++;
      $display("FAIL digit_limit: digits=%0d err=%b, want 5 1", digits, err);
    end
    press(3'b100, 4'd0);
    model_clear();
  endtask

  task automatic test_priority();
    press(3'b001, 4'd4);
    press(3'b001, 4'd2);
    checks++;
    if (acc !== 16'd42) begin
      errors++;
      $display("FAIL prio_setup: acc=%0d, want 42", acc);
    end
    press(3'b110, 4'd0);
    checks++;
    if (acc !== 16'd0 || digits !== 3'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_clr_commit: acc=%0d digits=%0d valid=%b, want 0 0 0",
               acc, digits, valid);
    end
    press(3'b010, 4'd0);
    checks++;
    if (valid !== 1'b1 || data !== 16'd0) begin
      errors++;
      $display("FAIL commit_empty: valid=%b data=%0d, want 1 0", valid, data);
    end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(2);
    model_clear();
  endtask

  task automatic test_random();
    int op;
    int d;
    press(3'b100, 4'd0);
    model_clear();
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        press(3'b100, 4'd0);
        model_clear();
      end else if (op == 1) begin
        press(3'b010, 4'($urandom_range(0, 15)));
        checks++;
        if (valid !== 1'b1 || data !== 16'(m_acc)) begin
          errors++;
          $display("FAIL rnd_commit[%0d]: valid=%b data=%0d, want 1 %0d", n, valid, data, m_acc);
        end
        cyc($urandom_range(0, 4));
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        model_clear();
      end else begin
        d = $urandom_range(0, 11);
        press(3'b001, 4'(d));
        model_enter(d);
      end
      checks++;
      if ({valid, acc, digits, err} !== {1'b0, 16'(m_acc), 3'(m_digits), m_err}) begin
        errors++;
        $display("FAIL rnd_state[%0d]: valid=%b acc=%0d digits=%0d err=%b, want 0 %0d %0d %b",
                 n, valid, acc, digits, err, m_acc, m_digits, m_err);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    press(3'b100, 4'd0);
    press(3'b001, 4'd9);
    press(3'b001, 4'd11);
    press(3'b010, 4'd0);
    checks++;
    if (valid !== 1'b1 || data !== 16'd9 || err !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: valid=%b data=%0d err=%b, want 1 9 1", valid, data, err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, data, acc, digits, err} !== 36'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b data=%0d acc=%0d digits=%0d err=%b, want all 0",
               valid, data, acc, digits, err);
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_handshake();
    test_overflow();
    test_invalid_limit();
    test_priority();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
